// File: rtl/priority_scan_enc_if.sv
// rtl/priority_scan_enc_if.sv - request-vector in / index-beat out handshake bundle for priority_scan_enc
interface priority_scan_enc_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_zero
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_zero
  );
endinterface

// File: rtl/priority_scan_enc.sv
// rtl/priority_scan_enc.sv - sequential priority encoder draining every set bit of a vector, one index per beat
// PRIORITY_SCAN_MSB_FIRST_EN selects highest-index-first order instead of the default lowest-index-first.
module priority_scan_enc #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  priority_scan_enc_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_last_q;
  logic [WIDTH-1:0] rem_clr;

  function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
`ifdef PRIORITY_SCAN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) idx = IDX_W'(i);
`else
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i]) idx = IDX_W'(i);
`endif
    return idx;
  endfunction

  // Clearing the lowest set bit leaves zero exactly when popcount <= 1.
  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    return (v & (v - WIDTH'(1))) == '0;
  endfunction

  assign rem_clr = rem_q & ~(WIDTH'(1) << out_idx_q);

  // Index and last flag are precomputed for the next beat so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem_q       <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rem_q       <= bus.in_vec;
            zero_q      <= (bus.in_vec == '0);
            out_idx_q   <= pick(bus.in_vec);
            out_last_q  <= at_most_one(bus.in_vec);
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              rem_q       <= '0;
              zero_q      <= 1'b0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state       <= IDLE;
            end else begin
              rem_q      <= rem_clr;
              out_idx_q  <= pick(rem_clr);
              out_last_q <= at_most_one(rem_clr);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_zero  = zero_q;
endmodule

// File: tb/tb_priority_scan_enc.sv
// tb/tb_priority_scan_enc.sv - directed scoreboard bench for priority_scan_enc
module tb_priority_scan_enc;
  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             zero;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  priority_scan_enc_if #(.WIDTH(WIDTH)) bus ();

  priority_scan_enc #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [WIDTH-1:0] v);
    int cnt;
    int n;
    beat_t b;
    cnt = $countones(v);
    n = 0;
    if (v == '0) begin
      b.idx = '0; b.last = 1'b1; b.zero = 1'b1;
      sb.push_back(b);
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
`ifdef PRIORITY_SCAN_MSB_FIRST_EN
        int i = WIDTH - 1 - k;
`else
        int i = k;
`endif
        if (v[i]) begin
          n++;
          b.idx = IDX_W'(i); b.last = (n == cnt); b.zero = 1'b0;
          sb.push_back(b);
        end
      end
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    chk("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    push_model(v);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_vec   = '0;
    chk("out_valid_latency", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic beat(output logic stop);
    beat_t e;
    stop = 1'b0;
    chk("beat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_underflow: observed beat idx %0h expected no beat", bus.out_idx);
      stop = 1'b1;
    end else if (bus.out_valid !== 1'b1) begin
      stop = 1'b1;
    end else begin
      e = sb.pop_front();
      chk("beat_idx", {28'd0, bus.out_idx}, {28'd0, e.idx});
      chk("beat_last", {31'd0, bus.out_last}, {31'd0, e.last});
      chk("beat_zero", {31'd0, bus.out_zero}, {31'd0, e.zero});
      stop = e.last;
      @(negedge clk);
    end
  endtask

  task automatic collect();
    logic stop;
    int n;
    stop = 1'b0;
    n = 0;
    bus.out_ready = 1'b1;
    while (!stop && n < WIDTH + 4) begin
      beat(stop);
      n++;
    end
    if (!stop) begin
      n_checks++;
      n_fail++;
      $error("FAIL collect_timeout: observed %0d beats expected last beat", n);
    end
    chk("sb_drained", sb.size(), 32'd0);
    chk("in_ready_after_last", {31'd0, bus.in_ready}, 32'd1);
    chk("out_valid_after_last", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_idx", {28'd0, bus.out_idx}, 32'd0);
    chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_out_zero", {31'd0, bus.out_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // zero vector
    send(16'h0000);
    collect();

    // sparse vector
    send(16'h8421);
    collect();

    // backpressure
    bus.out_ready = 1'b0;
    send(16'h0006);
    repeat (3) begin
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_idx_held", {28'd0, bus.out_idx}, {28'd0, sb[0].idx});
      chk("bp_last_held", {31'd0, bus.out_last}, 32'd0);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    collect();

    // reset mid-scan with a competing in_valid
    send(16'hFFFF);
    bus.out_ready = 1'b1;
    repeat (4) beat(s);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_vec = 16'h0003;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vec = '0;
    sb.delete();
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_out_idx", {28'd0, bus.out_idx}, 32'd0);
    chk("midrst_out_zero", {31'd0, bus.out_zero}, 32'd0);
    @(negedge clk);
    chk("midrst_no_capture", {31'd0, bus.out_valid}, 32'd0);
    send(16'h0002);
    collect();

    // all-ones with an ignored request during the scan
    send(16'hFFFF);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_vec = 16'h0001;
    beat(s);
    bus.in_valid = 1'b0;
    bus.in_vec = '0;
    collect();
    @(negedge clk);
    chk("busy_no_capture", {31'd0, bus.out_valid}, 32'd0);

    // boundary single bits and a few random vectors
    send(16'h8000);
    collect();
    send(16'h0001);
    collect();
    repeat (4) begin
      send(WIDTH'($urandom_range(0, 16'hFFFF)));
      collect();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/priority_scan_enc.md
Name: priority_scan_enc

Overview:
Parametrised, sequential successor to the 4-bit combinational priority encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake. It then emits the index of every set bit, one per output handshake, in priority order (LSB first by default). The last index is flagged. Used wherever all pending requests or flags must be serviced in priority order, e.g. interrupt or error-bit draining.

Parameters:
WIDTH, 16, request vector width; legal range 2..256.
IDX_W, $clog2(WIDTH), index width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_vec is valid
in_ready  output  1  block can accept a vector
in_vec  input  WIDTH  request vector; bit 0 is highest priority
out_valid  output  1  out_idx/out_last/out_zero are valid
out_ready  input  1  consumer accepts the current beat
out_idx  output  IDX_W  index of the highest-priority remaining set bit
out_last  output  1  current beat is the final beat for this vector
out_zero  output  1  captured vector was all-zero (single dummy beat)

Behaviour:
- Reset values: state=IDLE, rem_q=0, in_ready=1, out_valid=0, out_idx=0, out_last=0, out_zero=0.
- States: IDLE, SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: rem_q<=in_vec, zero_q<=(in_vec==0), go to SCAN.
- SCAN:
  - in_ready=0; in_valid is ignored (no capture, no error).
  - out_valid=1.
  - out_idx = lowest set index of rem_q; 0 when rem_q==0.
  - out_zero=zero_q.
  - out_last=1 when popcount(rem_q)<=1.
  - On out_valid&&out_ready with out_last=0: clear bit out_idx in rem_q, stay in SCAN.
  - On out_valid&&out_ready with out_last=1: rem_q<=0, zero_q<=0, go to IDLE.
- Latency: out_valid rises the cycle after input acceptance. In the steady state there is one beat per cycle while out_ready=1. Each vector costs one bubble cycle: in_ready rises the cycle after the last beat.
- Zero vector: exactly one beat with out_idx=0, out_zero=1, out_last=1. This matches the legacy all-zero -> 0 encoding; out_zero disambiguates it.
- Backpressure: while out_valid=1 and out_ready=0, out_idx, out_last and out_zero are held stable.
- Boundary bits: bit 0 and bit WIDTH-1 must both be emitted correctly. All-ones produces WIDTH beats, indices 0..WIDTH-1.
- Outputs are derived only from registered state (rem_q, zero_q, state). There is no combinational path from in_* to out_*, and no path from out_ready to in_ready.
- Reset mid-operation: rst dominates all other inputs in the same cycle. The pending vector is discarded and the next cycle shows reset values.

Optional Feature:
Macro PRIORITY_SCAN_MSB_FIRST_EN.
- Defined: priority is inverted. out_idx is the highest set index of rem_q, so indices are emitted in descending order. out_last and zero-vector handling are unchanged.
- Undefined: LSB-first order as described in Behaviour.
- Only the index-selection logic differs; ports, handshake and timing are identical.

Test Plan:
1. Zero vector: WIDTH=16, in_vec=0x0000 accepted -> next cycle a single beat with out_idx=0, out_zero=1, out_last=1; then in_ready=1.
2. Sparse vector: in_vec=0x8421 with out_ready=1 -> beats out_idx=0,5,10,15 on consecutive cycles; out_last=1 only on 15; out_zero=0 throughout.
3. Backpressure: in_vec=0x0006, out_ready low for 3 cycles -> out_idx=1 held stable with out_last=0; then beats 1, 2 (last); in_ready=0 until the cycle after the last beat.
4. Reset mid-scan: in_vec=0xFFFF, rst asserted after 4 beats (0..3) with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, no capture; then in_vec=0x0002 -> single beat out_idx=1, out_last=1.
5. Busy / all-ones: in_vec=0xFFFF, with in_valid pulsed 0x0001 during SCAN -> 16 beats, idx 0..15, last on 15; the 0x0001 is ignored.
6. Macro defined: in_vec=0x8421 -> beats 15,10,5,0 with out_last on 0; in_vec=0x0000 -> idx 0, out_zero=1, out_last=1.
